// File: rtl/mdu_ctrl.sv
// MIPS multiply/divide controller: iterative shift-add multiplier, restoring divider, HI/LO owner.
// Optional build macro MDU_FAST_MUL_EN selects a single-cycle multiply through IDLE->FIX.
module mdu_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_src1,
   input  logic [31:0] req_src2,
   output logic        req_ready,
   input  logic        flush,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] hilo_wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi_rdata,
   output logic [31:0] lo_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        is_div_q, is_div_d;
   logic        is_signed_q, is_signed_d;
   logic        neg_res_q, neg_res_d;
   logic        neg_rem_q, neg_rem_d;
   logic [31:0] operand_q, operand_d;
   logic [32:0] acc_hi_q, acc_hi_d;
   logic [31:0] acc_lo_q, acc_lo_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        accept;
   logic        req_div, req_signed;
   logic        sign1, sign2;
   logic [31:0] mag1, mag2;
   logic [32:0] mul_sum;
   logic [32:0] div_shift;
   logic [33:0] div_diff;
   logic [63:0] mul_res;
   logic [31:0] quo_res, rem_res;

`ifdef MDU_FAST_MUL_EN
   logic signed [32:0] fast_a, fast_b;
   logic signed [65:0] fast_prod;
`endif

   assign req_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == FIX) && !flush;
   assign hi_rdata  = hi_q;
   assign lo_rdata  = lo_q;

   assign accept     = req_valid && req_ready && !flush;
   assign req_div    = req_op[2] | req_op[3];
   assign req_signed = req_op[0] | req_op[2];
   assign sign1      = req_signed & req_src1[31];
   assign sign2      = req_signed & req_src2[31];
   assign mag1       = sign1 ? -req_src1 : req_src1;
   assign mag2       = sign2 ? -req_src2 : req_src2;

   // Multiply: add multiplicand into the upper half when the current multiplier LSB is set, then shift right.
   assign mul_sum   = acc_hi_q + (acc_lo_q[0] ? {1'b0, operand_q} : 33'd0);
   // Divide: shift in the next dividend bit and trial-subtract; a borrow means restore.
   assign div_shift = {acc_hi_q[31:0], acc_lo_q[31]};
   assign div_diff  = {1'b0, div_shift} - {2'b00, operand_q};

`ifdef MDU_FAST_MUL_EN
   assign fast_a    = {is_signed_q & operand_q[31], operand_q};
   assign fast_b    = {is_signed_q & acc_lo_q[31], acc_lo_q};
   assign fast_prod = fast_a * fast_b;
   assign mul_res   = fast_prod[63:0];
`else
   assign mul_res   = neg_res_q ? -{acc_hi_q[31:0], acc_lo_q} : {acc_hi_q[31:0], acc_lo_q};
`endif
   assign quo_res = neg_res_q ? -acc_lo_q : acc_lo_q;
   assign rem_res = neg_rem_q ? -acc_hi_q[31:0] : acc_hi_q[31:0];

   // NOTE: every signal written here gets a default first so no path leaves one unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      is_div_d    = is_div_q;
      is_signed_d = is_signed_q;
      neg_res_d   = neg_res_q;
      neg_rem_d   = neg_rem_q;
      operand_d   = operand_q;
      acc_hi_d    = acc_hi_q;
      acc_lo_d    = acc_lo_q;
      hi_d        = hi_q;
      lo_d        = lo_q;

      unique case (state_q)
         IDLE: begin
            if (hi_we) hi_d = hilo_wdata;
            if (lo_we) lo_d = hilo_wdata;
            if (accept) begin
               is_div_d    = req_div;
               is_signed_d = req_signed;
               neg_res_d   = sign1 ^ sign2;
               neg_rem_d   = sign1;
               cnt_d       = 5'd0;
               acc_hi_d    = 33'd0;
               state_d     = CALC;
               if (req_div) begin
                  acc_lo_d  = mag1;
                  operand_d = mag2;
               end else begin
`ifdef MDU_FAST_MUL_EN
                  acc_lo_d  = req_src2;
                  operand_d = req_src1;
                  state_d   = FIX;
`else
                  acc_lo_d  = mag2;
                  operand_d = mag1;
`endif
               end
            end
         end
         CALC: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               if (is_div_q) begin
                  if (!div_diff[33]) begin
                     acc_hi_d = div_diff[32:0];
                     acc_lo_d = {acc_lo_q[30:0], 1'b1};
                  end else begin
                     acc_hi_d = div_shift;
                     acc_lo_d = {acc_lo_q[30:0], 1'b0};
                  end
               end else begin
                  acc_hi_d = {1'b0, mul_sum[32:1]};
                  acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
               end
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_d = FIX;
            end
         end
         FIX: begin
            state_d = IDLE;
            if (!flush) begin
               if (is_div_q) begin
                  lo_d = quo_res;
                  hi_d = rem_res;
               end else begin
                  hi_d = mul_res[63:32];
                  lo_d = mul_res[31:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // NOTE: datapath registers are not reset; they are always loaded on accept before being used.
   always_ff @(posedge clk) begin
      is_div_q    <= is_div_d;
      is_signed_q <= is_signed_d;
      neg_res_q   <= neg_res_d;
      neg_rem_q   <= neg_rem_d;
      operand_q   <= operand_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl; honours MDU_FAST_MUL_EN for multiply latency.
module tb_mdu_ctrl;

   localparam logic [3:0] OP_MULT  = 4'b0001;
   localparam logic [3:0] OP_MULTU = 4'b0010;
   localparam logic [3:0] OP_DIV   = 4'b0100;
   localparam logic [3:0] OP_DIVU  = 4'b1000;
   localparam int ITER_LAT = 33;
`ifdef MDU_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [3:0]  req_op;
   logic [31:0] req_src1, req_src2;
   logic        req_ready;
   logic        flush, hi_we, lo_we;
   logic [31:0] hilo_wdata;
   logic        busy, done;
   logic [31:0] hi_rdata, lo_rdata;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;

   mdu_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_src1  (req_src1),
      .req_src2  (req_src2),
      .req_ready (req_ready),
      .flush     (flush),
      .hi_we     (hi_we),
      .lo_we     (lo_we),
      .hilo_wdata(hilo_wdata),
      .busy      (busy),
      .done      (done),
      .hi_rdata  (hi_rdata),
      .lo_rdata  (lo_rdata)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   // Issues one request, returns cycles from accept to done (-1 on timeout); ends one cycle after FIX.
   task automatic run_op(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                         output int lat);
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_src1 = s1; req_src2 = s2;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = -1;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         if (done === 1'b1) begin lat = n; break; end
      end
      @(posedge clk); #1;
   endtask

   task automatic write_hilo(input logic h, input logic l, input logic [31:0] d);
      @(negedge clk);
      hi_we = h; lo_we = l; hilo_wdata = d;
      @(posedge clk); #1;
      hi_we = 1'b0; lo_we = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      checks += 5;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      if (hi_rdata !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi_rdata); end
      if (lo_rdata !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo_rdata); end
   endtask

   task automatic expect_op(input string name, input logic [3:0] op, input logic [31:0] s1,
                            input logic [31:0] s2, input int exp_lat,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int lat;
      run_op(op, s1, s2, lat);
      checks += 4;
      if (lat != exp_lat) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_lat); end
      if (hi_rdata !== exp_hi) begin errors++; $display("FAIL %s_hi got=%h exp=%h", name, hi_rdata, exp_hi); end
      if (lo_rdata !== exp_lo) begin errors++; $display("FAIL %s_lo got=%h exp=%h", name, lo_rdata, exp_lo); end
      if (busy !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL %s_idle busy=%b ready=%b exp busy=0 ready=1", name, busy, req_ready);
      end
   endtask

   task automatic test_multiply();
      expect_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001);
      expect_op("mult_neg",  OP_MULT,  32'hFFFF_FFF9, 32'd3,         MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      expect_op("mult_min",  OP_MULT,  32'h8000_0000, 32'h8000_0000, MUL_LAT, 32'h4000_0000, 32'h0000_0000);
   endtask

   task automatic test_divide();
      expect_op("div_neg",   OP_DIV,  32'hFFFF_FFF9, 32'd2,         ITER_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      expect_op("divu_zero", OP_DIVU, 32'd7,         32'd0,         ITER_LAT, 32'h0000_0007, 32'hFFFF_FFFF);
      expect_op("div_negd",  OP_DIV,  32'd7,         32'hFFFF_FFFE, ITER_LAT, 32'h0000_0001, 32'hFFFF_FFFD);
      expect_op("div_zero",  OP_DIV,  32'hFFFF_FFFB, 32'd0,         ITER_LAT, 32'hFFFF_FFFB, 32'h0000_0001);
   endtask

   task automatic test_back_to_back();
      expect_op("b2b_mul", OP_MULTU, 32'd5,   32'd6, MUL_LAT,  32'd0, 32'd30);
      expect_op("b2b_div", OP_DIVU,  32'd30,  32'd4, ITER_LAT, 32'd2, 32'd7);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_width got=%b exp=0", done); end
   endtask

   task automatic test_hilo_write();
      logic [31:0] hi_before;
      bit seen;
      hi_before = hi_rdata;
      @(negedge clk);
      req_valid = 1'b1; req_op = OP_DIVU; req_src1 = 32'd100; req_src2 = 32'd3;
      @(posedge clk); #1;
      req_valid = 1'b0;
      write_hilo(1'b1, 1'b0, 32'h1234_5678);
      checks++;
      if (hi_rdata !== hi_before) begin errors++; $display("FAIL mthi_busy got=%h exp=%h", hi_rdata, hi_before); end
      seen = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (done === 1'b1) begin seen = 1; break; end
      end
      @(posedge clk); #1;
      checks += 3;
      if (!seen) begin errors++; $display("FAIL mthi_busy_timeout got=none exp=done"); end
      if (hi_rdata !== 32'd1) begin errors++; $display("FAIL mthi_busy_rem got=%h exp=1", hi_rdata); end
      if (lo_rdata !== 32'd33) begin errors++; $display("FAIL mthi_busy_quo got=%h exp=21", lo_rdata); end
      write_hilo(1'b1, 1'b0, 32'h1234_5678);
      checks += 2;
      if (hi_rdata !== 32'h1234_5678) begin errors++; $display("FAIL mthi_idle got=%h exp=12345678", hi_rdata); end
      if (lo_rdata !== 32'd33) begin errors++; $display("FAIL mthi_idle_lo got=%h exp=21", lo_rdata); end
      write_hilo(1'b0, 1'b1, 32'hCAFE_0001);
      checks++;
      if (lo_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL mtlo_idle got=%h exp=cafe0001", lo_rdata); end
   endtask

   task automatic test_flush();
      int dc;
      write_hilo(1'b1, 1'b1, 32'h1111_1111);
      dc = done_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_op = OP_DIV; req_src1 = 32'd100; req_src2 = 32'd3;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checks += 5;
      if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", busy); end
      if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", req_ready); end
      if (hi_rdata !== 32'h1111_1111) begin errors++; $display("FAIL flush_hi got=%h exp=11111111", hi_rdata); end
      if (lo_rdata !== 32'h1111_1111) begin errors++; $display("FAIL flush_lo got=%h exp=11111111", lo_rdata); end
      if (done_cnt != dc) begin errors++; $display("FAIL flush_done got=%0d pulses exp=0", done_cnt - dc); end
      expect_op("post_flush", OP_DIV, 32'd100, 32'd3, ITER_LAT, 32'd1, 32'd33);
      // Flush in IDLE must block the accept in the same cycle.
      @(negedge clk);
      req_valid = 1'b1; req_op = OP_DIVU; req_src1 = 32'd9; req_src2 = 32'd2; flush = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; flush = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_accept busy=%b exp=0", busy); end
   endtask

   task automatic test_reset_mid();
      int dc;
      dc = done_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_op = OP_DIVU; req_src1 = 32'd1000; req_src2 = 32'd7;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks += 5;
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
      if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", req_ready); end
      if (hi_rdata !== 32'd0) begin errors++; $display("FAIL rst_mid_hi got=%h exp=0", hi_rdata); end
      if (lo_rdata !== 32'd0) begin errors++; $display("FAIL rst_mid_lo got=%h exp=0", lo_rdata); end
      repeat (40) @(posedge clk);
      #1;
      if (done_cnt != dc) begin errors++; $display("FAIL rst_mid_done got=%0d pulses exp=0", done_cnt - dc); end
      expect_op("post_reset", OP_DIVU, 32'd1000, 32'd7, ITER_LAT, 32'd6, 32'd142);
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_src1 = 32'd0; req_src2 = 32'd0;
      flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; hilo_wdata = 32'd0;
      test_reset();
      test_multiply();
      test_divide();
      test_back_to_back();
      test_hilo_write();
      test_flush();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the 5-stage MIPS pipeline. It sits beside the EX stage and accepts MULT/MULTU/DIV/DIVU operations through a valid/ready handshake. It sequences the iterative shift-add multiplier and restoring divider, and owns the architectural HI/LO registers. It also provides the busy indication that ID/EX use to stall dependent MFHI/MFLO.

## Interface
Parameters:
- none

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  EX presents an MDU operation
- req_op  in  4  one-hot: [0] mult, [1] multu, [2] div, [3] divu
- req_src1  in  32  rs value (multiplicand / dividend)
- req_src2  in  32  rt value (multiplier / divisor)
- req_ready  out  1  controller can accept; equals (state==IDLE)
- flush  in  1  abort the in-flight operation (exception path)
- hi_we  in  1  MTHI write
- lo_we  in  1  MTLO write
- hilo_wdata  in  32  MTHI/MTLO data
- busy  out  1  operation in flight (state != IDLE)
- done  out  1  one-cycle pulse in the cycle HI/LO are written with a result
- hi_rdata  out  32  current HI register
- lo_rdata  out  32  current LO register

## Operation
- States: IDLE, CALC, FIX.
- IDLE, accept (req_valid && req_ready):
  - Latch the op.
  - Latch magnitudes |src1| and |src2| for signed ops; raw values for unsigned ops.
  - Latch the sign flags.
  - Clear the 5-bit counter.
  - Go to CALC (or FIX, see Configuration).
- CALC: one iteration per cycle, counter 0..31; at counter==31 go to FIX.
  - Multiply: 64-bit shift-add, one multiplier bit per cycle, LSB first.
  - Divide: restoring, one quotient bit per cycle, MSB first; 33-bit partial remainder.
- FIX, single cycle:
  - Apply signed correction: product negated if src1 sign ^ src2 sign; quotient negated if sign1^sign2; remainder takes the dividend sign.
  - Write the result into HI/LO at the end of the cycle: mult → HI=product[63:32], LO=product[31:0]; div → LO=quotient, HI=remainder.
  - Assert done.
  - Go to IDLE.
- Divide by zero: run the algorithm unmodified. Quotient magnitude = 0xFFFFFFFF, remainder magnitude = |dividend|, then apply the sign correction. No exception.
- Reads of hi_rdata/lo_rdata are direct register outputs. ID stalls MFHI/MFLO while busy=1.
- hi_we/lo_we:
  - Applied only when busy=0; ignored while busy=1.
  - If accepted in the same cycle as an accept, the write is applied, and the operation's later completion overwrites it.
- flush:
  - In CALC or FIX: return to IDLE next cycle; HI/LO unchanged; done not asserted.
  - In IDLE: flush suppresses any accept in that cycle.
- Reset:
  - Outputs: state=IDLE, HI=LO=0, counter=0, done=0, busy=0, req_ready=1.
  - Reset mid-operation discards the operation.

## Timing
- Accept at rising edge T. busy=1 from cycle T+1.
- Iterative op: CALC occupies cycles T+1..T+32, FIX at T+33 (done=1). New HI/LO are visible from T+34; busy=0 and req_ready=1 at T+34.
- Back-to-back: a second request can be accepted at the T+34 edge.
- done is combinational from state==FIX, unregistered; it is never high for more than one consecutive cycle per operation.
- Flush asserted in cycle C: busy=0 in cycle C+1.

## Configuration
- MDU_FAST_MUL_EN defined:
  - mult/multu skip CALC: IDLE→FIX. FIX computes the 64-bit product with a single-cycle multiplier (`*` operator on 33-bit sign/zero-extended operands).
  - done is asserted at T+1; HI/LO are visible at T+2.
  - Divide is unaffected.
- Undefined: all ops use the 32-cycle iterative path above.

## Test plan
- multu 0xFFFFFFFF × 0xFFFFFFFF → done at T+33 (T+1 with MDU_FAST_MUL_EN); HI=0xFFFFFFFE, LO=0x00000001.
- mult −7 (0xFFFFFFF9) × 3 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- div −7 ÷ 2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1); divu 7 ÷ 0 → LO=0xFFFFFFFF, HI=0x00000007.
- Start div 100÷3 with HI=LO=0x11111111, assert flush at T+10 → busy=0 at T+11, no done pulse, HI=LO=0x11111111; immediate new request accepted.
- Assert hi_we with 0x12345678 while busy → HI unchanged; repeat in IDLE → HI=0x12345678 next cycle.
- Assert reset at T+5 of a divide → next cycle busy=0, req_ready=1, HI=LO=0, done never pulses.
